// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin through one shared full adder, LSB first.
// Latency: done pulses WIDTH cycles after the accepted start; start is ignored while busy.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result bits enter at the MSB so after WIDTH shifts bit 0 holds the first sum bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        res_sh <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    res_sh <= {fa_s, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum  <= {fa_s, res_sh[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: WIDTH=8 vector table plus corner sequences, and an exhaustive WIDTH=2 sweep.

module tb_serial_add_ctrl;
    logic       clk;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    exp_t q8[$];
    exp_t q2[$];

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards: pop and compare whenever a DUT signals done.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'(done8), 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sum8", 32'(sum8), 32'(e.s));
                check("cout8", 32'(cout8), 32'(e.c));
                check("done8_cycle", cyc, e.cyc);
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                check("done2_unexpected", 32'(done2), 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("sum2", 32'(sum2), 32'(e.s));
                check("cout2", 32'(cout2), 32'(e.c));
                check("done2_cycle", cyc, e.cyc);
            end
        end
    end

    // One WIDTH=8 operation; operands are scrambled right after the accept edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec);
        logic [7:0] ps;
        logic       pc;
        int         bc;
        int         n;
        logic       stable;
        exp_t       e;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        e.s = es; e.c = ec; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        ps = sum8; pc = cout8;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = 8'($urandom); cin8 = ~c;
        bc = 0; n = 0; stable = 1'b1;
        while (busy8 && n < 40) begin
            if (!done8 && (sum8 !== ps || cout8 !== pc)) stable = 1'b0;
            bc++; n++;
            @(negedge clk);
        end
        check("busy8_timeout", 32'(busy8), 32'd0);
        check("busy8_cycles", bc, 9);
        check("sum8_stable_in_run", 32'(stable), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h3C, 8'h11, 1'b0, 8'h4D, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        #3;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_sum2", 32'(sum2), 32'd0);

        // start held during reset must not be taken
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        check("no_accept_in_rst", 32'(busy8), 32'd0);

        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);
        end

        // start held high: second accept in the IDLE cycle after DONE, mid-RUN changes ignored
        begin
            exp_t e;
            int   n;
            @(negedge clk);
            start8 = 1'b1; a8 = 8'h3C; b8 = 8'h11; cin8 = 1'b0;
            e.s = 8'h4D; e.c = 1'b0; e.cyc = cyc + 1 + 8;
            q8.push_back(e);
            e.s = 8'h03; e.c = 1'b0; e.cyc = cyc + 1 + 8 + 2 + 8;
            q8.push_back(e);
            @(negedge clk);
            a8 = 8'h01; b8 = 8'h02;
            n = 0;
            while (!done8 && n < 40) begin n++; @(negedge clk); end
            check("hold_done_seen", 32'(done8), 32'd1);
            @(negedge clk);
            check("hold_idle_gap", 32'(busy8), 32'd0);
            @(negedge clk);
            check("hold_reaccept", 32'(busy8), 32'd1);
            start8 = 1'b0;
            n = 0;
            while (busy8 && n < 40) begin n++; @(negedge clk); end
            check("hold_timeout", 32'(busy8), 32'd0);
        end

        // reset at RUN bit 4 aborts with no done pulse
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_sum8", 32'(sum8), 32'd0);
        check("abort_cout8", 32'(cout8), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (12) @(negedge clk);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

        // exhaustive WIDTH=2
        for (int i = 0; i < 32; i++) begin
            exp_t       e;
            logic [2:0] t;
            int         n;
            @(negedge clk);
            a2 = i[4:3]; b2 = i[2:1]; cin2 = i[0]; start2 = 1'b1;
            t = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
            e.s = {6'b0, t[1:0]}; e.c = t[2]; e.cyc = cyc + 1 + 2;
            q2.push_back(e);
            @(negedge clk);
            start2 = 1'b0; a2 = ~a2; b2 = ~b2; cin2 = ~cin2;
            n = 0;
            while (busy2 && n < 20) begin n++; @(negedge clk); end
            check("busy2_timeout", 32'(busy2), 32'd0);
        end

        repeat (4) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, captured only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, captured only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result of the last completed operation.
REQ-011 The block SHALL have port cout, output, 1 bit: carry-out of the last completed operation.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin using exactly one 1-bit full_adder instance (inputs a, b, cin; outputs sum, cout), time-shared over WIDTH cycles, LSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL, at that clock edge, capture a, b and cin into internal shift/carry registers, clear the bit counter to 0 and go to RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 On each edge in RUN, the block SHALL feed the current LSBs of the operand registers and the carry register to the full adder.
REQ-017 On each edge in RUN, the block SHALL shift the adder sum bit into the MSB of the result shift register, shift both operand registers right by one, load the adder carry into the carry register, and increment the counter.
REQ-018 On the RUN edge where the counter equals WIDTH-1, the block SHALL go to DONE and load sum (from the completed result shift register) and cout (from the final adder carry) in that same edge.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH and low otherwise.
REQ-021 sum and cout SHALL hold their values until the next operation's DONE entry; they SHALL NOT change during RUN.
REQ-022 start SHALL be ignored in RUN and DONE: no operand recapture, no counter change and no lengthening of the operation.
REQ-023 After DONE, a new start SHALL be accepted only in the following IDLE cycle, so the minimum start-to-start spacing is WIDTH+2 cycles.
REQ-024 Changes on a, b and cin outside the accepting edge SHALL have no effect on the result.
REQ-025 Carry out of the MSB SHALL appear only on cout; there SHALL be no wrap into sum bit 0.

Reset
REQ-026 When rst=1, the block SHALL immediately (asynchronously) set the state to IDLE and clear to zero busy, done, sum, cout, the counter, the carry register and the operand and result shift registers.
REQ-027 Assertion of rst in RUN or DONE SHALL abort the operation, with no done pulse for the aborted operation.
REQ-028 start SHALL not be accepted on any edge where rst=1; the first possible accept is the first edge after rst deasserts.

Verification
REQ-029 WIDTH=8, start with a=0x00, b=0x00, cin=0 -> done 8 cycles after accept; sum=0x00, cout=0; busy high for 9 cycles.
REQ-030 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; sum/cout unchanged from their prior values during RUN.
REQ-031 WIDTH=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a second case a=0x3C, b=0x11, cin=0 -> sum=0x4D, cout=0.
REQ-032 Hold start=1 continuously and change a/b mid-RUN -> the first result uses only the operands captured at the accept edge; the next accept occurs exactly in the IDLE cycle after DONE.
REQ-033 Assert rst for 1 cycle at RUN bit 4 -> outputs zero at once, no done pulse; a fresh start after reset with a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0.
REQ-034 Exhaustive check with WIDTH=2 (all 32 combinations of a, b, cin) against a+b+cin -> all match.
